// File: rtl/control_monitor.sv
// rtl/control_monitor.sv - passive step-sequence, CPI and protocol monitor for the multicycle controller
// Optional body watchdog: define CONTROL_MONITOR_WATCHDOG_EN.
module control_monitor #(
  parameter int CNT_W    = 16,
  parameter int MAX_BODY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegDst,
  input  logic             ALUSrcA,
  input  logic             RegWrite,
  input  logic             MemToReg,
  input  logic             IRWrite,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             mem_select,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       PCSource,
  input  logic [2:0]       ALUOp,
  input  logic             alu_zero,
  output logic             instr_done,
  output logic [1:0]       retire_kind,
  output logic             branch_taken,
  output logic [3:0]       last_cpi,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic             err,
  output logic [2:0]       err_code
);

  typedef enum logic [1:0] {S_SYNC, S_FETCHED, S_BODY, S_RETIRED} state_t;

  state_t     state, state_nxt;
  logic [3:0] cpi_cnt, cpi_nxt, cpi_inc;
  logic       is_fetch, is_retire, is_quiet, mem_conflict;
  logic [1:0] kind;
  logic       err_nxt, done_nxt, taken_nxt;
  logic [2:0] code_nxt;
  logic       unused_ctrl;

  // Datapath-steering controls carry no sequencing information.
  assign unused_ctrl = ^{RegDst, ALUSrcA, mem_select, ALUSrcB, PCSource, ALUOp};

  assign is_fetch     = IRWrite & MemRead & PCWrite;
  assign is_retire    = !is_fetch & (RegWrite | MemWrite | PCWriteCond | PCWrite);
  assign is_quiet     = !(RegWrite | MemWrite | PCWrite | PCWriteCond | IRWrite);
  assign mem_conflict = MemRead & MemWrite;
  assign cpi_inc      = (cpi_cnt == 4'hF) ? cpi_cnt : cpi_cnt + 4'd1;

  always_comb begin
    kind = 2'd3;
    if (MemWrite)                 kind = 2'd2;
    else if (RegWrite & MemToReg) kind = 2'd1;
    else if (RegWrite)            kind = 2'd0;
  end

`ifdef CONTROL_MONITOR_WATCHDOG_EN
  localparam int BW = $clog2(MAX_BODY + 1);
  logic [BW-1:0] body_cnt, body_nxt;
`else
  localparam int unused_max_body = MAX_BODY;
`endif

  always_comb begin
    state_nxt = state;
    cpi_nxt   = cpi_cnt;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    done_nxt  = 1'b0;
    taken_nxt = 1'b0;
`ifdef CONTROL_MONITOR_WATCHDOG_EN
    body_nxt  = body_cnt;
`endif
    if (mem_conflict) begin
      err_nxt  = 1'b1;
      code_nxt = 3'd4;
    end else begin
      case (state)
        S_SYNC: begin
          if (is_fetch) begin
            state_nxt = S_FETCHED;
            cpi_nxt   = 4'd1;
          end
        end
        S_FETCHED: begin
          if (is_quiet) begin
            state_nxt = S_BODY;
            cpi_nxt   = cpi_inc;
`ifdef CONTROL_MONITOR_WATCHDOG_EN
            body_nxt  = '0;
`endif
          end else begin
            err_nxt  = 1'b1;
            code_nxt = 3'd1;
          end
        end
        S_BODY: begin
          if (is_fetch) begin
            err_nxt  = 1'b1;
            code_nxt = 3'd3;
          end else if (is_retire) begin
            state_nxt = S_RETIRED;
            done_nxt  = 1'b1;
            taken_nxt = PCWriteCond & alu_zero;
          end else begin
            cpi_nxt = cpi_inc;
`ifdef CONTROL_MONITOR_WATCHDOG_EN
            // The cycle that would bring the body count to MAX_BODY trips the watchdog.
            if (body_cnt == BW'(MAX_BODY - 1)) begin
              err_nxt  = 1'b1;
              code_nxt = 3'd2;
            end else begin
              body_nxt = body_cnt + BW'(1);
            end
`endif
          end
        end
        S_RETIRED: begin
          if (is_fetch) begin
            state_nxt = S_FETCHED;
            cpi_nxt   = 4'd1;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = 3'd3;
          end
        end
        default: state_nxt = S_SYNC;
      endcase
    end
    if (err_nxt) state_nxt = S_SYNC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_SYNC;
      cpi_cnt      <= '0;
      instr_done   <= 1'b0;
      retire_kind  <= '0;
      branch_taken <= 1'b0;
      last_cpi     <= '0;
      cycle_count  <= '0;
      instr_count  <= '0;
      err          <= 1'b0;
      err_code     <= '0;
    end else begin
      state        <= state_nxt;
      cpi_cnt      <= cpi_nxt;
      instr_done   <= done_nxt;
      branch_taken <= taken_nxt;
      err          <= err_nxt;
      err_code     <= code_nxt;
      if (done_nxt) begin
        retire_kind <= kind;
        last_cpi    <= cpi_inc;
        if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
      end
      if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

`ifdef CONTROL_MONITOR_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) body_cnt <= '0;
    else        body_cnt <= body_nxt;
  end
`endif

endmodule

// File: tb/tb_control_monitor.sv
// tb/tb_control_monitor.sv - randomized self-checking bench for control_monitor against a cycle-level protocol model
// Honours CONTROL_MONITOR_WATCHDOG_EN in the model as well as the DUT.
module tb_control_monitor;

  localparam int MAX_BODY = 4;
`ifdef CONTROL_MONITOR_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam int T_FETCH = 0, T_QUIET = 1, T_ALU = 2, T_LOAD = 3, T_STORE = 4;
  localparam int T_BRANCH = 5, T_JUMP = 6, T_CONFLICT = 7, T_JUNK = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic RegDst, ALUSrcA, RegWrite, MemToReg, IRWrite, MemWrite, MemRead;
  logic PCWrite, PCWriteCond, mem_select, alu_zero;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;

  logic        instr_done, branch_taken, err;
  logic [1:0]  retire_kind;
  logic [3:0]  last_cpi;
  logic [2:0]  err_code;
  logic [15:0] cycle_count, instr_count;

  logic        s_instr_done, s_branch_taken, s_err;
  logic [1:0]  s_retire_kind;
  logic [3:0]  s_last_cpi;
  logic [2:0]  s_err_code;
  logic [3:0]  s_cycle_count, s_instr_count;

  control_monitor #(.CNT_W(16), .MAX_BODY(MAX_BODY)) dut (
    .clk(clk), .reset(reset), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .IRWrite(IRWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .mem_select(mem_select),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .alu_zero(alu_zero),
    .instr_done(instr_done), .retire_kind(retire_kind), .branch_taken(branch_taken),
    .last_cpi(last_cpi), .cycle_count(cycle_count), .instr_count(instr_count),
    .err(err), .err_code(err_code)
  );

  control_monitor #(.CNT_W(4), .MAX_BODY(MAX_BODY)) dut_s (
    .clk(clk), .reset(reset), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .IRWrite(IRWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .mem_select(mem_select),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .alu_zero(alu_zero),
    .instr_done(s_instr_done), .retire_kind(s_retire_kind), .branch_taken(s_branch_taken),
    .last_cpi(s_last_cpi), .cycle_count(s_cycle_count), .instr_count(s_instr_count),
    .err(s_err), .err_code(s_err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_len is the number of cycles of the instruction in flight (0 = none),
  // m_wait means an instruction just retired and a fetch must follow.
  int m_len, m_cyc, m_instr, m_kind, m_cpi, m_code;
  bit m_wait, m_done, m_taken, m_err;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic m_reset();
    m_len = 0; m_wait = 0; m_cyc = 0; m_instr = 0; m_kind = 0; m_cpi = 0; m_code = 0;
    m_done = 0; m_taken = 0; m_err = 0;
  endtask

  task automatic m_error(input int code);
    m_err = 1; m_code = code; m_len = 0; m_wait = 0;
  endtask

  task automatic model_cycle();
    bit f, r, q;
    f = IRWrite && MemRead && PCWrite;
    r = !f && (RegWrite || MemWrite || PCWriteCond || PCWrite);
    q = !(RegWrite || MemWrite || PCWrite || PCWriteCond || IRWrite);
    m_done = 0; m_taken = 0; m_err = 0;
    m_cyc++;
    if (MemRead && MemWrite) m_error(4);
    else if (m_wait) begin
      if (f) begin m_len = 1; m_wait = 0; end
      else m_error(3);
    end else if (m_len == 0) begin
      if (f) m_len = 1;
    end else if (m_len == 1) begin
      if (q) m_len = 2;
      else m_error(1);
    end else if (f) m_error(3);
    else if (r) begin
      m_done  = 1;
      m_cpi   = (m_len + 1 > 15) ? 15 : m_len + 1;
      m_kind  = MemWrite ? 2 : (RegWrite && MemToReg) ? 1 : RegWrite ? 0 : 3;
      m_taken = PCWriteCond && alu_zero;
      m_instr++;
      m_len = 0; m_wait = 1;
    end else begin
      m_len++;
      if (WD && (m_len - 2) >= MAX_BODY) m_error(2);
    end
  endtask

  task automatic compare_all();
    check("instr_done", instr_done, m_done);
    check("branch_taken", branch_taken, m_taken);
    check("err", err, m_err);
    check("err_code", err_code, m_code);
    check("retire_kind", retire_kind, m_kind);
    check("last_cpi", last_cpi, m_cpi);
    check("cycle_count", cycle_count, sat(m_cyc, 16));
    check("instr_count", instr_count, sat(m_instr, 16));
    check("sat_cycle_count", s_cycle_count, sat(m_cyc, 4));
    check("sat_instr_count", s_instr_count, sat(m_instr, 4));
  endtask

  task automatic drive(input int t, input bit z);
    {RegDst, ALUSrcA, RegWrite, MemToReg, IRWrite, MemWrite, MemRead, PCWrite, PCWriteCond, mem_select} = '0;
    ALUSrcB  = 2'($urandom);
    PCSource = 2'($urandom);
    ALUOp    = 3'($urandom);
    alu_zero = z;
    case (t)
      T_FETCH:    begin IRWrite = 1; MemRead = 1; PCWrite = 1; end
      T_QUIET:    begin RegDst = 1'($urandom); ALUSrcA = 1'($urandom); mem_select = 1'($urandom); end
      T_ALU:      begin RegWrite = 1; RegDst = 1; end
      T_LOAD:     begin RegWrite = 1; MemToReg = 1; end
      T_STORE:    begin MemWrite = 1; mem_select = 1; end
      T_BRANCH:   PCWriteCond = 1;
      T_JUMP:     PCWrite = 1;
      T_CONFLICT: begin MemRead = 1; MemWrite = 1; end
      default:    {RegDst, ALUSrcA, RegWrite, MemToReg, IRWrite, MemWrite, MemRead,
                   PCWrite, PCWriteCond, mem_select} = 10'($urandom);
    endcase
  endtask

  task automatic step(input int t, input bit z);
    drive(t, z);
    @(posedge clk);
    model_cycle();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_reset();
    compare_all();
    check("reset_instr_done", instr_done, 0);
    check("reset_err_code", err_code, 0);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;
  endtask

  task automatic rand_instr();
    int body;
    body = $urandom_range(0, 5);
    if ($urandom_range(0, 9) == 0) step(T_JUNK, 1'($urandom));
    step(T_FETCH, 1'($urandom));
    step(T_QUIET, 1'($urandom));
    for (int i = 0; i < body; i++) begin
      if ($urandom_range(0, 19) == 0) step(($urandom_range(0, 1) == 0) ? T_CONFLICT : T_JUNK, 1'($urandom));
      else step(T_QUIET, 1'($urandom));
    end
    step($urandom_range(T_ALU, T_JUMP), 1'($urandom));
  endtask

  initial begin
    m_reset();
    drive(T_QUIET, 0);
    @(posedge clk);
    do_reset();

    step(T_FETCH, 0); step(T_QUIET, 0); step(T_QUIET, 0); step(T_ALU, 0);
    check("rtype_done", instr_done, 1);
    check("rtype_kind", retire_kind, 0);
    check("rtype_cpi", last_cpi, 4);
    check("rtype_icount", instr_count, 1);
    step(T_FETCH, 0); step(T_QUIET, 0); step(T_BRANCH, 1);
    check("beq_taken", branch_taken, 1);
    check("beq_done", instr_done, 1);
    check("beq_kind", retire_kind, 3);
    check("beq_cpi", last_cpi, 3);
    step(T_FETCH, 0); step(T_QUIET, 0); step(T_BRANCH, 0);
    check("bne_taken", branch_taken, 0);
    check("bne_done", instr_done, 1);

    step(T_FETCH, 0); step(T_QUIET, 0); step(T_QUIET, 0);
    do_reset();
    check("midbody_reset_icount", instr_count, 0);

    step(T_FETCH, 0); step(T_QUIET, 0); step(T_QUIET, 0); step(T_QUIET, 0); step(T_LOAD, 0);
    check("load_kind", retire_kind, 1);
    check("load_cpi", last_cpi, 5);
    step(T_FETCH, 0); step(T_QUIET, 0); step(T_QUIET, 0); step(T_STORE, 0);
    check("store_kind", retire_kind, 2);
    check("store_cpi", last_cpi, 4);
    check("ls_icount", instr_count, 2);

    step(T_FETCH, 0); step(T_FETCH, 0);
    check("fetch_fetch_err", err, 1);
    check("fetch_fetch_code", err_code, 1);
    step(T_QUIET, 0);
    check("err_pulse_clear", err, 0);
    check("err_code_held", err_code, 1);
    step(T_FETCH, 0); step(T_QUIET, 0); step(T_CONFLICT, 0);
    check("conflict_code", err_code, 4);
    step(T_QUIET, 0); step(T_ALU, 0);
    check("sync_retire_ignored", instr_count, 2);
    step(T_FETCH, 0); step(T_QUIET, 0); step(T_ALU, 0);
    check("resync_counted", instr_count, 3);

    step(T_FETCH, 0);
    for (int i = 1; i <= 6; i++) begin
      step(T_QUIET, 0);
      if (i == 5) begin
        check("watchdog_err", err, WD ? 1 : 0);
        check("watchdog_code", err_code, WD ? 2 : 4);
      end
    end
    step(T_STORE, 0);

    for (int n = 0; n < 400; n++) rand_instr();

    for (int n = 0; n < 20; n++) begin
      step(T_FETCH, 0); step(T_QUIET, 0); step(T_ALU, 0);
    end
    check("sat_instr_hold", s_instr_count, 15);
    check("sat_cycle_hold", s_cycle_count, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
